// File: rtl/qspi_arb_if.sv
// Signal bundle between the qspi line-transfer arbiter, its requesters and the qspi port.
// The DMA (x_) group exists only when QSPI_ARB_DMA_EN is defined.
interface qspi_arb_if #(
    parameter int TW = 20
);
    logic          i_req;
    logic [TW-1:0] i_tag;
    logic          i_mem;
    logic          i_wstrobe;
    logic          i_done;

    logic          d_req;
    logic          d_write;
    logic          d_mem;
    logic [TW-1:0] d_tag;
    logic [3:0]    d_dwrite;
    logic          d_wstrobe;
    logic          d_rstrobe;
    logic          d_done;

`ifdef QSPI_ARB_DMA_EN
    logic          x_req;
    logic          x_write;
    logic          x_mem;
    logic [TW-1:0] x_tag;
    logic [3:0]    x_dwrite;
    logic          x_wstrobe;
    logic          x_rstrobe;
    logic          x_done;
`endif

    logic          q_req;
    logic          q_i_d;
    logic          q_mem;
    logic          q_write;
    logic [TW-1:0] q_paddr;
    logic [3:0]    q_dwrite;
    logic          q_wstrobe_in;
    logic          q_rstrobe_in;
    logic          q_done;

    logic          timeout_err;

`ifdef QSPI_ARB_DMA_EN
    modport slave (
        input  i_req, i_tag, i_mem,
        output i_wstrobe, i_done,
        input  d_req, d_write, d_mem, d_tag, d_dwrite,
        output d_wstrobe, d_rstrobe, d_done,
        input  x_req, x_write, x_mem, x_tag, x_dwrite,
        output x_wstrobe, x_rstrobe, x_done,
        output q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
        input  q_wstrobe_in, q_rstrobe_in, q_done,
        output timeout_err
    );

    modport master (
        output i_req, i_tag, i_mem,
        input  i_wstrobe, i_done,
        output d_req, d_write, d_mem, d_tag, d_dwrite,
        input  d_wstrobe, d_rstrobe, d_done,
        output x_req, x_write, x_mem, x_tag, x_dwrite,
        input  x_wstrobe, x_rstrobe, x_done,
        input  q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
        output q_wstrobe_in, q_rstrobe_in, q_done,
        input  timeout_err
    );
`else
    modport slave (
        input  i_req, i_tag, i_mem,
        output i_wstrobe, i_done,
        input  d_req, d_write, d_mem, d_tag, d_dwrite,
        output d_wstrobe, d_rstrobe, d_done,
        output q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
        input  q_wstrobe_in, q_rstrobe_in, q_done,
        output timeout_err
    );

    modport master (
        output i_req, i_tag, i_mem,
        input  i_wstrobe, i_done,
        output d_req, d_write, d_mem, d_tag, d_dwrite,
        input  d_wstrobe, d_rstrobe, d_done,
        input  q_req, q_i_d, q_mem, q_write, q_paddr, q_dwrite,
        output q_wstrobe_in, q_rstrobe_in, q_done,
        input  timeout_err
    );
`endif
endinterface

// File: rtl/qspi_arb.sv
// Round-robin line-transfer arbiter in front of the shared qspi port, with a BUSY watchdog.
// Define QSPI_ARB_DMA_EN to add the DMA (x_) requester to the I -> D -> X rotation.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no owner; pick a round-robin winner and latch its request
// S_BUSY   | q_req high, strobes routed to owner, watchdog counting
// S_RELEASE| owner's _done pulses; requests ignored for this one cycle
module qspi_arb #(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    qspi_arb_if.slave   bus
);
    localparam int LB = $clog2(LINE_LENGTH);
    localparam int TW = PA - LB;
    localparam logic [7:0] WD_TC = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_X} own_t;

`ifdef QSPI_ARB_DMA_EN
    localparam own_t LAST_RST = OWN_X;
`else
    localparam own_t LAST_RST = OWN_D;
`endif

    state_t        state, state_nxt;
    own_t          own, own_nxt;
    own_t          last, last_nxt;
    own_t          winner;
    logic [7:0]    wd_cnt, wd_cnt_nxt;
    logic          terr, terr_nxt;
    logic [TW-1:0] paddr_r, paddr_nxt;
    logic          write_r, write_nxt;
    logic          mem_r, mem_nxt;

    logic          x_req_w;
    logic          x_write_w;
    logic          x_mem_w;
    logic [TW-1:0] x_tag_w;
    logic [3:0]    x_dwrite_w;

`ifdef QSPI_ARB_DMA_EN
    assign x_req_w    = bus.x_req;
    assign x_write_w  = bus.x_write;
    assign x_mem_w    = bus.x_mem;
    assign x_tag_w    = bus.x_tag;
    assign x_dwrite_w = bus.x_dwrite;
`else
    assign x_req_w    = 1'b0;
    assign x_write_w  = 1'b0;
    assign x_mem_w    = 1'b0;
    assign x_tag_w    = '0;
    assign x_dwrite_w = 4'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            own     <= OWN_NONE;
            last    <= LAST_RST;
            wd_cnt  <= 8'h00;
            terr    <= 1'b0;
            paddr_r <= '0;
            write_r <= 1'b0;
            mem_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            own     <= own_nxt;
            last    <= last_nxt;
            wd_cnt  <= wd_cnt_nxt;
            terr    <= terr_nxt;
            paddr_r <= paddr_nxt;
            write_r <= write_nxt;
            mem_r   <= mem_nxt;
        end
    end

    // Search starts just after the last owner; push vs pull carries no weight.
    always_comb begin
        winner = OWN_NONE;
        case (last)
            OWN_I: begin
                if (bus.d_req)      winner = OWN_D;
                else if (x_req_w)   winner = OWN_X;
                else if (bus.i_req) winner = OWN_I;
            end
            OWN_D: begin
                if (x_req_w)        winner = OWN_X;
                else if (bus.i_req) winner = OWN_I;
                else if (bus.d_req) winner = OWN_D;
            end
            default: begin
                if (bus.i_req)      winner = OWN_I;
                else if (bus.d_req) winner = OWN_D;
                else if (x_req_w)   winner = OWN_X;
            end
        endcase
    end

    always_comb begin
        state_nxt  = state;
        own_nxt    = own;
        last_nxt   = last;
        wd_cnt_nxt = wd_cnt;
        terr_nxt   = terr;
        paddr_nxt  = paddr_r;
        write_nxt  = write_r;
        mem_nxt    = mem_r;

        case (state)
            S_IDLE: begin
                if (winner != OWN_NONE) begin
                    state_nxt  = S_BUSY;
                    own_nxt    = winner;
                    wd_cnt_nxt = 8'h00;
                    case (winner)
                        OWN_I: begin
                            paddr_nxt = bus.i_tag;
                            write_nxt = 1'b0;
                            mem_nxt   = bus.i_mem;
                        end
                        OWN_D: begin
                            paddr_nxt = bus.d_tag;
                            write_nxt = bus.d_write;
                            mem_nxt   = bus.d_mem;
                        end
                        OWN_X: begin
                            paddr_nxt = x_tag_w;
                            write_nxt = x_write_w;
                            mem_nxt   = x_mem_w;
                        end
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // A real completion on the last allowed cycle wins over the abort.
                if (bus.q_done) begin
                    state_nxt = S_RELEASE;
                end else if (wd_cnt == WD_TC) begin
                    state_nxt = S_RELEASE;
                    terr_nxt  = 1'b1;
                end else begin
                    wd_cnt_nxt = wd_cnt + 8'h01;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
                last_nxt  = own;
                own_nxt   = OWN_NONE;
            end
            default: begin
                state_nxt = S_IDLE;
                own_nxt   = OWN_NONE;
            end
        endcase
    end

    logic busy;
    logic rel;
    assign busy = (state == S_BUSY);
    assign rel  = (state == S_RELEASE);

    always_comb begin
        bus.q_req       = busy;
        bus.q_i_d       = (own == OWN_I);
        bus.q_write     = write_r;
        bus.q_mem       = mem_r;
        bus.q_paddr     = paddr_r;
        bus.timeout_err = terr;

        bus.q_dwrite = 4'h0;
        if (busy && own == OWN_D) bus.q_dwrite = bus.d_dwrite;
        if (busy && own == OWN_X) bus.q_dwrite = x_dwrite_w;

        bus.i_wstrobe = busy && (own == OWN_I) && bus.q_wstrobe_in;
        bus.i_done    = rel && (own == OWN_I);

        bus.d_wstrobe = busy && (own == OWN_D) && bus.q_wstrobe_in;
        bus.d_rstrobe = busy && (own == OWN_D) && bus.q_rstrobe_in;
        bus.d_done    = rel && (own == OWN_D);

`ifdef QSPI_ARB_DMA_EN
        bus.x_wstrobe = busy && (own == OWN_X) && bus.q_wstrobe_in;
        bus.x_rstrobe = busy && (own == OWN_X) && bus.q_rstrobe_in;
        bus.x_done    = rel && (own == OWN_X);
`endif
    end
endmodule

// File: tb/tb_qspi_arb.sv
// Scoreboard bench for qspi_arb: stimulus queues expected grants/completions, a monitor checks them.
// Build with QSPI_ARB_DMA_EN to also exercise the DMA requester.
module tb_qspi_arb;
    localparam int TW = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qspi_arb_if #(.TW(TW)) bus ();

    qspi_arb #(.PA(22), .LINE_LENGTH(4), .TIMEOUT(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic          i_d;
        logic          wr;
        logic          mem;
    } grant_t;

    typedef struct {
        logic [2:0] who;   // {x, d, i}
        logic       terr;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];

    int errors = 0;
    int checks = 0;
    int i_ws_cnt = 0;
    int d_ws_cnt = 0;
    int d_rs_cnt = 0;
    int x_rs_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic       prev_qreq = 1'b0;
    logic [2:0] who;
    grant_t     g;
    done_t      e;

    always @(negedge clk) begin
        if (bus.q_req && !prev_qreq) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", 32'(bus.q_paddr), 32'hFFFF_FFFF);
            end else begin
                g = gq.pop_front();
                chk("grant_tag",   32'(bus.q_paddr), 32'(g.tag));
                chk("grant_i_d",   32'(bus.q_i_d),   32'(g.i_d));
                chk("grant_write", 32'(bus.q_write), 32'(g.wr));
                chk("grant_mem",   32'(bus.q_mem),   32'(g.mem));
            end
        end
        prev_qreq = bus.q_req;

`ifdef QSPI_ARB_DMA_EN
        who = {bus.x_done, bus.d_done, bus.i_done};
`else
        who = {1'b0, bus.d_done, bus.i_done};
`endif
        if (who != 3'b000) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'(who), 32'h0);
            end else begin
                e = dq.pop_front();
                chk("done_owner", 32'(who), 32'(e.who));
                chk("done_terr",  32'(bus.timeout_err), 32'(e.terr));
            end
        end

        if (bus.i_wstrobe) i_ws_cnt++;
        if (bus.d_wstrobe) d_ws_cnt++;
        if (bus.d_rstrobe) d_rs_cnt++;
`ifdef QSPI_ARB_DMA_EN
        if (bus.x_rstrobe) x_rs_cnt++;
`endif
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic wait_qreq(input string name);
        int n = 0;
        while (!bus.q_req && n < 30) begin
            tick;
            n++;
        end
        checks++;
        if (!bus.q_req) begin
            errors++;
            $display("FAIL %s: q_req got 0 expected 1 within 30 cycles", name);
        end
    endtask

    // Drives both (or all three) requesters continuously for four grants.
    task automatic rotate4(input string name);
        for (int k = 0; k < 4; k++) begin
            wait_qreq(name);
            tick;
            tick;
            bus.q_done = 1'b1;
            tick;
            bus.q_done = 1'b0;
            if (k == 3) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
`ifdef QSPI_ARB_DMA_EN
                bus.x_req = 1'b0;
`endif
            end
            tick;
        end
        repeat (4) tick;
    endtask

    int base_i, base_dw, base_dr, base_xr, n;

    initial begin
        bus.i_req = 0; bus.i_tag = '0; bus.i_mem = 0;
        bus.d_req = 0; bus.d_write = 0; bus.d_mem = 0; bus.d_tag = '0; bus.d_dwrite = 4'h0;
`ifdef QSPI_ARB_DMA_EN
        bus.x_req = 0; bus.x_write = 0; bus.x_mem = 0; bus.x_tag = '0; bus.x_dwrite = 4'h0;
`endif
        bus.q_wstrobe_in = 0; bus.q_rstrobe_in = 0; bus.q_done = 0;

        // Reset state
        repeat (3) tick;
        chk("rst_q_req",   32'(bus.q_req),       32'h0);
        chk("rst_q_i_d",   32'(bus.q_i_d),       32'h0);
        chk("rst_q_paddr", 32'(bus.q_paddr),     32'h0);
        chk("rst_q_dwrite",32'(bus.q_dwrite),    32'h0);
        chk("rst_i_done",  32'(bus.i_done),      32'h0);
        chk("rst_d_done",  32'(bus.d_done),      32'h0);
        chk("rst_terr",    32'(bus.timeout_err), 32'h0);
        reset = 1'b0;
        tick;

        // Single I fetch, one-cycle grant latency, strobe routing
        gq.push_back('{20'h12345, 1'b1, 1'b0, 1'b1});
        bus.i_req = 1; bus.i_tag = 20'h12345; bus.i_mem = 1;
        tick;
        chk("lat_q_req",   32'(bus.q_req),   32'h1);
        chk("lat_q_i_d",   32'(bus.q_i_d),   32'h1);
        chk("lat_q_paddr", 32'(bus.q_paddr), 32'h12345);
        bus.i_req = 0;
        base_i = i_ws_cnt; base_dw = d_ws_cnt;
        for (int k = 0; k < 4; k++) begin
            bus.q_wstrobe_in = 1;
            if (k == 0) begin
                #1;
                chk("i_wstrobe_comb", 32'(bus.i_wstrobe), 32'h1);
            end
            tick;
            bus.q_wstrobe_in = 0;
            tick;
        end
        chk("i_wstrobe_count", 32'(i_ws_cnt - base_i),  32'd4);
        chk("d_wstrobe_quiet", 32'(d_ws_cnt - base_dw), 32'd0);
        dq.push_back('{3'b001, 1'b0});
        bus.q_done = 1;
        tick;
        bus.q_done = 0;
        chk("i_done_pulse",  32'(bus.i_done), 32'h1);
        chk("q_req_dropped", 32'(bus.q_req),  32'h0);
        tick;
        chk("i_done_single", 32'(bus.i_done), 32'h0);
        tick;

        // I and D held together: I, D, I, D
        do_reset;
        for (int k = 0; k < 2; k++) begin
            gq.push_back('{20'h00111, 1'b1, 1'b0, 1'b0});
            gq.push_back('{20'h00222, 1'b0, 1'b0, 1'b1});
            dq.push_back('{3'b001, 1'b0});
            dq.push_back('{3'b010, 1'b0});
        end
        bus.i_tag = 20'h00111; bus.i_mem = 0;
        bus.d_tag = 20'h00222; bus.d_mem = 1; bus.d_write = 0;
        bus.i_req = 1; bus.d_req = 1;
        rotate4("alt_id");

        // D push: write nibble and read strobes
        gq.push_back('{20'h0ABCD, 1'b0, 1'b1, 1'b0});
        bus.d_req = 1; bus.d_write = 1; bus.d_mem = 0; bus.d_tag = 20'h0ABCD; bus.d_dwrite = 4'hA;
        tick;
        bus.d_req = 0;
        chk("push_q_dwrite", 32'(bus.q_dwrite), 32'hA);
        base_i = i_ws_cnt; base_dr = d_rs_cnt; base_xr = x_rs_cnt;
        for (int k = 0; k < 8; k++) begin
            bus.q_rstrobe_in = 1;
            if (k == 0) begin
                #1;
                chk("d_rstrobe_comb", 32'(bus.d_rstrobe), 32'h1);
            end
            tick;
            bus.q_rstrobe_in = 0;
            tick;
        end
        chk("d_rstrobe_count", 32'(d_rs_cnt - base_dr), 32'd8);
        chk("i_wstrobe_none",  32'(i_ws_cnt - base_i),  32'd0);
        chk("x_rstrobe_none",  32'(x_rs_cnt - base_xr), 32'd0);
        dq.push_back('{3'b010, 1'b0});
        bus.q_done = 1;
        tick;
        bus.q_done = 0;
        bus.d_write = 0;
        tick;
        tick;

        // Watchdog abort after 20 BUSY cycles
        gq.push_back('{20'h00055, 1'b0, 1'b0, 1'b1});
        dq.push_back('{3'b010, 1'b1});
        bus.d_req = 1; bus.d_tag = 20'h00055; bus.d_mem = 1;
        tick;
        bus.d_req = 0;
        n = 0;
        while (!bus.d_done && n < 40) begin
            tick;
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd20);
        chk("timeout_err",    32'(bus.timeout_err), 32'h1);
        bus.q_wstrobe_in = 1;
        #1;
        chk("no_strobe_after_abort", 32'(bus.d_wstrobe), 32'h0);
        bus.q_wstrobe_in = 0;
        tick;
        tick;
        // Stray q_done while idle must not produce a completion
        bus.q_done = 1;
        tick;
        bus.q_done = 0;
        chk("idle_q_done_ignored", 32'(bus.q_req), 32'h0);
        tick;

        // I serviced normally after the abort, error stays sticky
        gq.push_back('{20'hFFFFF, 1'b1, 1'b0, 1'b0});
        dq.push_back('{3'b001, 1'b1});
        bus.i_req = 1; bus.i_tag = 20'hFFFFF; bus.i_mem = 0;
        tick;
        bus.i_req = 0;
        repeat (3) tick;
        bus.q_done = 1;
        tick;
        bus.q_done = 0;
        tick;
        tick;

        // Reset in the middle of a transfer
        gq.push_back('{20'h00777, 1'b0, 1'b0, 1'b0});
        bus.d_req = 1; bus.d_tag = 20'h00777; bus.d_mem = 0;
        tick;
        bus.d_req = 0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst_q_req",  32'(bus.q_req),       32'h0);
        chk("midrst_d_done", 32'(bus.d_done),      32'h0);
        chk("midrst_terr",   32'(bus.timeout_err), 32'h0);
        repeat (4) tick;
        chk("midrst_idle", 32'(bus.q_req), 32'h0);

`ifdef QSPI_ARB_DMA_EN
        // I, D, X all held: I, D, X, I
        gq.push_back('{20'h00111, 1'b1, 1'b0, 1'b0});
        gq.push_back('{20'h00222, 1'b0, 1'b0, 1'b1});
        gq.push_back('{20'h00333, 1'b0, 1'b1, 1'b1});
        gq.push_back('{20'h00111, 1'b1, 1'b0, 1'b0});
        dq.push_back('{3'b001, 1'b0});
        dq.push_back('{3'b010, 1'b0});
        dq.push_back('{3'b100, 1'b0});
        dq.push_back('{3'b001, 1'b0});
        bus.i_tag = 20'h00111; bus.i_mem = 0;
        bus.d_tag = 20'h00222; bus.d_mem = 1; bus.d_write = 0;
        bus.x_tag = 20'h00333; bus.x_mem = 1; bus.x_write = 1; bus.x_dwrite = 4'h5;
        bus.i_req = 1; bus.d_req = 1; bus.x_req = 1;
        rotate4("rr_idx");
`endif

        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("done_queue_drained",  32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end
endmodule

// File: doc/qspi_arb.md
# qspi_arb

Line-transfer arbiter sharing the single `qspi` flash/PSRAM port between the instruction cache refill path, the data cache refill/writeback path and, optionally, a DMA requester. It replaces the ad-hoc `ifetch`-steered request/tag mux at the top level. It latches one line-transfer request at a time, presents it to `qspi`, routes per-nibble strobes to the owner, and signals completion. A watchdog aborts transfers that never finish.

## Interface
- `PA`, 22: physical address width.
- `LINE_LENGTH`, 4: cache line bytes; `LB = $clog2(LINE_LENGTH)`, tag width `TW = PA-LB`.
- `TIMEOUT`, 255: max cycles in BUSY before abort (8-bit counter; must be 1..255).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `i_req`  in  1  icache needs line (read).
- `i_tag`  in  TW  icache line address.
- `i_mem`  in  1  target memory select (rom_enable).
- `i_wstrobe`  out  1  nibble for icache valid on shared `dread`.
- `i_done`  out  1  icache transfer complete pulse.
- `d_req`, `d_write`, `d_mem`  in  1 each  dcache request, 1=push(writeback), memory select.
- `d_tag`  in  TW  dcache line address.
- `d_dwrite`  in  4  dcache write nibble.
- `d_wstrobe`, `d_rstrobe`, `d_done`  out  1 each  pull nibble valid, push nibble consumed, completion.
- `x_req`, `x_write`, `x_mem`, `x_tag`, `x_dwrite`, `x_wstrobe`, `x_rstrobe`, `x_done`: DMA equivalents of the `d_` ports (present only with `QSPI_ARB_DMA_EN`).
- `q_req`  out  1  transfer request to qspi.
- `q_i_d`  out  1  1 = instruction fetch.
- `q_mem`, `q_write`  out  1 each  latched attributes.
- `q_paddr`  out  TW  latched line address.
- `q_dwrite`  out  4  write nibble from owner.
- `q_wstrobe_in`, `q_rstrobe_in`, `q_done`  in  1 each  qspi nibble-in, nibble-out, transfer-finished pulse.
- `timeout_err`  out  1  sticky; set on watchdog abort, cleared by reset.

## Operation
- States: IDLE, BUSY, RELEASE. Owner register `own` ∈ {NONE, I, D, X}.
- IDLE: if any request is asserted, pick a winner, latch its tag/write/mem into `q_paddr/q_write/q_mem`, set `q_i_d=(own==I)`, go BUSY. Each `x_` output is 0 when `own` is not that requester.
- Priority: round-robin over I→D→X→I starting after `last` (last owner granted). `last` resets to X, so I wins a simultaneous first request. A push (`d_write=1`) is not prioritised over a pull.
- BUSY: `q_req=1`. `q_wstrobe_in`/`q_rstrobe_in` are routed combinationally to the owner's `_wstrobe`/`_rstrobe`; other strobes stay 0. `q_dwrite` selects the owner's nibble (0 for I). Requester inputs are ignored except the owner's `_dwrite`.
- `q_done` in BUSY: assert owner's `_done` for exactly one cycle (registered), go RELEASE, `q_req=0`.
- RELEASE: one cycle; requests ignored. The owner must drop `_req` by the end of this cycle; a request still high in IDLE is treated as a new transfer. Then IDLE, `own=NONE`, `last` updated.
- Watchdog: 8-bit counter cleared on BUSY entry, increments each BUSY cycle. When it reaches `TIMEOUT` without `q_done`: set `timeout_err`, pulse owner's `_done`, go RELEASE. No strobes are forwarded after the abort.
- `q_done` outside BUSY is ignored. Strobes outside BUSY are dropped.

## Timing
- Reset values: all outputs 0, state IDLE, `own=NONE`, `last=X`, counter 0, `timeout_err=0`.
- Request sampled in IDLE at cycle N → `q_req`, `q_paddr` valid at N+1.
- `q_done` at cycle M → `_done`=1 and `q_req`=0 at M+1; IDLE at M+2; the earliest next `q_req` is M+3.
- Strobe routing has zero latency (combinational from `q_*_in` and registered `own`).
- Reset mid-transfer: next cycle IDLE, `q_req=0`, and no `_done` pulse is issued. `qspi` is reset with the same signal.
- Back-to-back: with I and D both held high continuously, grants alternate I, D, I…

## Configuration
- `QSPI_ARB_DMA_EN` defined: the X requester ports exist and take part in round-robin I→D→X.
- Undefined: the X ports are absent and arbitration is I/D alternation. `last` resets to D, so I still wins the first tie. `own` is never X.

## Test plan
- Reset, then `i_req=1`, `i_tag=0x12345`, then `q_done` 8 cycles later → `q_req`/`q_i_d`=1 and `q_paddr=0x12345` one cycle after the request; `i_done` pulses one cycle after `q_done`; `q_req`=0.
- `i_req` and `d_req` asserted together and held → grant order I, D, I, D; `d_done` never precedes the first `i_done`.
- D push owner with `d_dwrite=0xA`, 8 `q_rstrobe_in` pulses → 8 `d_rstrobe` pulses, `q_dwrite=0xA`, no `i_wstrobe`/`x_rstrobe` activity.
- `TIMEOUT=20`, D granted, `q_done` withheld → after 20 BUSY cycles `timeout_err=1` and `d_done` pulses; a following I request is serviced normally.
- Reset asserted 3 cycles into a BUSY transfer → `q_req=0` next cycle, no `_done` pulse, `timeout_err=0`.
- With `QSPI_ARB_DMA_EN`, I, D and X all requesting continuously → grant order I, D, X, I.
